// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one serial multiplier between NUM_REQ requesters
// Ports: clk_i/rst_ni clock and async active-low reset; req_start_i/req_op_a_i/req_op_b_i
// per-requester request pulse and flattened operands; req_ready_o/req_prod_o per-requester
// result pulse and held product; mult_start_o/mult_op_a_o/mult_op_b_o/mult_ready_i/mult_prod_i
// multiplier handshake; busy_o any job queued or in flight; overrun_o sticky duplicate start.
module mult_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OP_A_W  = 24,
  parameter int OP_B_W  = 16,
  parameter int PROD_W  = OP_A_W + OP_B_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_start_i,
  input  logic [NUM_REQ*OP_A_W-1:0]   req_op_a_i,
  input  logic [NUM_REQ*OP_B_W-1:0]   req_op_b_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ*PROD_W-1:0]   req_prod_o,
  output logic                        mult_start_o,
  output logic [OP_A_W-1:0]           mult_op_a_o,
  output logic [OP_B_W-1:0]           mult_op_b_o,
  input  logic                        mult_ready_i,
  input  logic [PROD_W-1:0]           mult_prod_i,
  output logic                        busy_o,
  output logic                        overrun_o
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0][OP_A_W-1:0] op_a_q;
  logic [NUM_REQ-1:0][OP_B_W-1:0] op_b_q;
  logic [NUM_REQ-1:0][PROD_W-1:0] prod_q;
  logic [IW-1:0] rr, grant, gnt_idx;
  logic gnt_ok;
  assign req_prod_o = prod_q;
  assign busy_o = (state != IDLE) || (|pend);
  // Scan from farthest to nearest after rr so the nearest pending requester wins.
  always_comb begin
    gnt_ok = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (pend[IW'((int'(rr) + i) % NUM_REQ)]) begin
        gnt_ok = 1'b1;
        gnt_idx = IW'((int'(rr) + i) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      pend         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      prod_q       <= '0;
      rr           <= IW'(NUM_REQ - 1);
      grant        <= '0;
      req_ready_o  <= '0;
      mult_start_o <= 1'b0;
      mult_op_a_o  <= '0;
      mult_op_b_o  <= '0;
      overrun_o    <= 1'b0;
    end else begin
      mult_start_o <= 1'b0;
      req_ready_o  <= '0;
      for (int n = 0; n < NUM_REQ; n++) begin
        if (req_start_i[n]) begin
          if (pend[n]) overrun_o <= 1'b1;
          else begin
            pend[n]   <= 1'b1;
            op_a_q[n] <= req_op_a_i[n*OP_A_W +: OP_A_W];
            op_b_q[n] <= req_op_b_i[n*OP_B_W +: OP_B_W];
          end
        end
      end
      // Grant clear comes after capture so it wins on the granted slot.
      case (state)
        IDLE: if (gnt_ok) begin
          mult_op_a_o   <= op_a_q[gnt_idx];
          mult_op_b_o   <= op_b_q[gnt_idx];
          pend[gnt_idx] <= 1'b0;
          rr            <= gnt_idx;
          grant         <= gnt_idx;
          mult_start_o  <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (mult_ready_i) begin
          prod_q[grant]      <= mult_prod_i;
          req_ready_o[grant] <= 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter with a behavioural serial multiplier
module tb_mult_arbiter;
  localparam int NR = 2, AW = 24, BW = 16, PW = 40, MLAT = 4;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NR-1:0] req_start_i = '0;
  logic [NR*AW-1:0] req_op_a_i = '0;
  logic [NR*BW-1:0] req_op_b_i = '0;
  logic [NR-1:0] req_ready_o;
  logic [NR*PW-1:0] req_prod_o;
  logic mult_start_o;
  logic [AW-1:0] mult_op_a_o;
  logic [BW-1:0] mult_op_b_o;
  logic mult_ready_i;
  logic [PW-1:0] mult_prod_i;
  logic busy_o, overrun_o;
  int vectors = 0, errors = 0, n_starts = 0;
  int exp_id[$];
  logic [PW-1:0] exp_prod[$];
  int got_ids[$];
  int sb_id;
  logic [PW-1:0] sb_p;
  logic signed [AW-1:0] ma;
  logic signed [BW-1:0] mb;
  int mcnt;
  mult_arbiter #(.NUM_REQ(NR), .OP_A_W(AW), .OP_B_W(BW), .PROD_W(PW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_start_i(req_start_i), .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .req_ready_o(req_ready_o), .req_prod_o(req_prod_o),
    .mult_start_o(mult_start_o), .mult_op_a_o(mult_op_a_o), .mult_op_b_o(mult_op_b_o),
    .mult_ready_i(mult_ready_i), .mult_prod_i(mult_prod_i),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcnt <= 0;
      mult_ready_i <= 1'b0;
      mult_prod_i <= '0;
      ma <= '0;
      mb <= '0;
    end else begin
      mult_ready_i <= 1'b0;
      if (mult_start_o) begin
        ma <= mult_op_a_o;
        mb <= mult_op_b_o;
        mcnt <= MLAT;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          mult_ready_i <= 1'b1;
          mult_prod_i <= ma * mb;
        end
      end
    end
  end
  always @(negedge clk_i) begin
    if (mult_start_o) n_starts++;
    for (int n = 0; n < NR; n++) begin
      if (req_ready_o[n]) begin
        got_ids.push_back(n);
        vectors++;
        if (exp_id.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: req%0d ready with product %0d, required no result", n, $signed(req_prod_o[n*PW +: PW]));
        end else begin
          sb_id = exp_id.pop_front();
          sb_p = exp_prod.pop_front();
          if (sb_id !== n || req_prod_o[n*PW +: PW] !== sb_p) begin
            errors++;
            $display("FAIL sb_result: got req%0d product %0d, required req%0d product %0d", n, $signed(req_prod_o[n*PW +: PW]), sb_id, $signed(sb_p));
          end
        end
      end
    end
  end
  task automatic set_req(input int n, input logic signed [AW-1:0] a, input logic signed [BW-1:0] b, input bit push);
    logic signed [PW-1:0] p;
    req_start_i[n] = 1'b1;
    req_op_a_i[n*AW +: AW] = a;
    req_op_b_i[n*BW +: BW] = b;
    p = a * b;
    if (push) begin
      exp_id.push_back(n);
      exp_prod.push_back(p);
    end
  endtask
  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (!busy_o && req_ready_o == '0 && exp_id.size() == 0) break;
    end
    vectors++;
    if (k == 300) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b outstanding=%0d, required idle within 300 cycles", tag, busy_o, exp_id.size());
    end
  endtask
  task automatic wait_mult_start(input string tag);
    int k;
    for (k = 0; k < 50 && !mult_start_o; k++) @(negedge clk_i);
    vectors++;
    if (k == 50) begin
      errors++;
      $display("FAIL %s_start_timeout: no mult_start_o, required within 50 cycles", tag);
    end
  endtask
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    vectors += 3;
    if ({req_ready_o, mult_start_o, busy_o, overrun_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b start=%b busy=%b overrun=%b, required all 0", req_ready_o, mult_start_o, busy_o, overrun_o);
    end
    if (req_prod_o !== '0) begin
      errors++;
      $display("FAIL reset_prod: got %h, required 0", req_prod_o);
    end
    if ({mult_op_a_o, mult_op_b_o} !== '0) begin
      errors++;
      $display("FAIL reset_ops: got a=%h b=%h, required 0", mult_op_a_o, mult_op_b_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask
  task automatic test_both();
    int s0 = n_starts;
    set_req(0, 24'sd5, 16'sd7, 1);
    set_req(1, -24'sd2, 16'sd9, 1);
    @(negedge clk_i);
    req_start_i = '0;
    wait_idle("both");
    vectors++;
    if (n_starts - s0 != 2) begin
      errors++;
      $display("FAIL both_starts: got %0d mult_start_o pulses, required 2", n_starts - s0);
    end
  endtask
  task automatic test_fairness();
    int issued = 2;
    int k;
    bit ok = 1'b1;
    got_ids.delete();
    set_req(0, -24'sd1000, 16'sd3, 1);
    set_req(1, 24'sd77, -16'sd5, 1);
    for (k = 0; k < 400 && issued < 6; k++) begin
      @(negedge clk_i);
      req_start_i = '0;
      for (int n = 0; n < NR; n++)
        if (req_ready_o[n] && issued < 6) begin
          set_req(n, 24'(issued * 1111 - 3000), 16'(issued + 2), 1);
          issued++;
        end
    end
    @(negedge clk_i);
    req_start_i = '0;
    vectors++;
    if (issued != 6) begin
      errors++;
      $display("FAIL fair_issue: got %0d jobs requested, required 6", issued);
    end
    wait_idle("fair");
    if (got_ids.size() != 6) ok = 1'b0;
    else for (int i = 0; i < 6; i++) if (got_ids[i] != i % 2) ok = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL fair_order: got %0d grants %p, required 0,1,0,1,0,1", got_ids.size(), got_ids);
    end
  endtask
  task automatic test_overrun();
    int s0 = n_starts;
    vectors++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: got %b, required 0", overrun_o);
    end
    set_req(1, 24'sd4, 16'sd4, 1);
    @(negedge clk_i);
    set_req(1, 24'sd9, 16'sd9, 0);
    @(negedge clk_i);
    req_start_i = '0;
    wait_idle("overrun");
    vectors += 2;
    if (n_starts - s0 != 1) begin
      errors++;
      $display("FAIL overrun_jobs: got %0d mult_start_o pulses, required 1", n_starts - s0);
    end
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got %b, required 1", overrun_o);
    end
  endtask
  task automatic test_single();
    logic [PW-1:0] p1 = req_prod_o[PW +: PW];
    int r1 = 0;
    set_req(0, -24'sd3, 16'sd200, 1);
    @(negedge clk_i);
    req_start_i = '0;
    vectors++;
    if (mult_start_o !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got mult_start_o=%b one cycle after start, required 0", mult_start_o);
    end
    @(negedge clk_i);
    vectors += 2;
    if (mult_start_o !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got mult_start_o=%b two cycles after start, required 1", mult_start_o);
    end
    if (mult_op_a_o !== 24'hFFFFFD || mult_op_b_o !== 16'd200) begin
      errors++;
      $display("FAIL single_ops: got a=%0d b=%0d, required a=-3 b=200", $signed(mult_op_a_o), mult_op_b_o);
    end
    for (int k = 0; k < 300 && (busy_o || req_ready_o != '0 || exp_id.size() != 0); k++) begin
      @(negedge clk_i);
      if (req_ready_o[1]) r1++;
    end
    wait_idle("single");
    vectors += 4;
    if (r1 != 0 || req_prod_o[PW +: PW] !== p1) begin
      errors++;
      $display("FAIL single_other: got req1 pulses=%0d prod=%0d, required 0 pulses prod=%0d", r1, $signed(req_prod_o[PW +: PW]), $signed(p1));
    end
    if (req_prod_o[0 +: PW] !== -40'sd600) begin
      errors++;
      $display("FAIL single_held: got req0 prod %0d, required -600", $signed(req_prod_o[0 +: PW]));
    end
    if (mult_op_a_o !== 24'hFFFFFD || mult_op_b_o !== 16'd200) begin
      errors++;
      $display("FAIL single_op_hold: got a=%0d b=%0d idle, required a=-3 b=200", $signed(mult_op_a_o), mult_op_b_o);
    end
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun_o);
    end
  endtask
  task automatic test_requeue();
    int early = 0;
    int k;
    set_req(0, 24'sd123, -16'sd45, 1);
    @(negedge clk_i);
    req_start_i = '0;
    wait_mult_start("requeue");
    @(negedge clk_i);
    set_req(0, -24'sd7, 16'sd11, 1);
    @(negedge clk_i);
    req_start_i = '0;
    for (k = 0; k < 50 && !req_ready_o[0]; k++) begin
      if (mult_start_o) early++;
      @(negedge clk_i);
    end
    vectors++;
    if (k == 50 || early != 0) begin
      errors++;
      $display("FAIL requeue_order: got %0d early starts, first ready seen=%0b, required 0 early and ready", early, k != 50);
    end
    wait_idle("requeue");
  endtask
  task automatic test_reset_wait();
    int g0;
    set_req(1, 24'sd3, 16'sd3, 1);
    @(negedge clk_i);
    req_start_i = '0;
    wait_mult_start("rstwait");
    @(negedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    exp_id.delete();
    exp_prod.delete();
    vectors += 3;
    if ({req_ready_o, mult_start_o, busy_o, overrun_o} !== '0) begin
      errors++;
      $display("FAIL rstwait_ctrl: got ready=%b start=%b busy=%b overrun=%b, required all 0", req_ready_o, mult_start_o, busy_o, overrun_o);
    end
    if (req_prod_o !== '0) begin
      errors++;
      $display("FAIL rstwait_prod: got %h, required 0", req_prod_o);
    end
    if ({mult_op_a_o, mult_op_b_o} !== '0) begin
      errors++;
      $display("FAIL rstwait_ops: got a=%h b=%h, required 0", mult_op_a_o, mult_op_b_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    g0 = got_ids.size();
    repeat (20) @(negedge clk_i);
    vectors++;
    if (got_ids.size() != g0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_stale: got %0d ready pulses busy=%b after release, required 0 and 0", got_ids.size() - g0, busy_o);
    end
  endtask
  initial begin
    test_reset();
    test_both();
    test_fairness();
    test_overrun();
    test_single();
    test_requeue();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
